freq_en_pio_edge: RTL and testbench
===================================

// Module: freq_en_pio_edge
// PURPOSE
//  Parametrised Avalon-MM input PIO for the frequency-meter gate/enable signals.
//  Successor to the 1-bit, read-only enable input: N-bit port, input synchroniser,
//  per-bit edge capture, and a maskable interrupt to the Nios II CPU.
//  Sits between the fabric-side measurement logic and the Nios II data master.
// PARAMETERS
//  WIDTH        8   input port width, 1..32
//  SYNC_STAGES  2   synchroniser flops on in_port, 2..4
//  EDGE_TYPE    0   capture on: 0 = rising, 1 = falling, 2 = any edge
//  BIT_CLEARING 1   1 = edge_capture write-1-to-clear per bit; 0 = any write clears all
// PORTS
//  clk        in   1      system clock
//  reset      in   1      synchronous, active-high reset
//  address    in   2      register select
//  chipselect in   1      slave select
//  write_n    in   1      active-low write strobe (valid with chipselect)
//  writedata  in   32     write data
//  in_port    in   WIDTH  asynchronous external inputs
//  readdata   out  32     registered read data
//  irq        out  1      level interrupt to CPU
// BEHAVIOUR
//  Register map (upper bits above WIDTH read 0, writes ignored):
//   0 data         RO  synchronised in_port (last sync stage)
//   1 reserved     RO  reads 0
//   2 irq_mask     RW  bit i enables irq from edge_capture[i]
//   3 edge_capture RW  sticky per-bit edge flags; cleared per BIT_CLEARING
//  Write = chipselect & ~write_n, takes effect on that clk edge.
//  readdata: updated every clk from address (no read strobe), 1-cycle latency;
//   reset value 0.
//  Synchroniser: SYNC_STAGES flops, then one 'prev' flop; all reset to 0.
//  Edge detect on sync vs prev: rise = s&~p, fall = ~s&p, any = s^p.
//  Arming: an arm counter suppresses edge capture for SYNC_STAGES+1 cycles after
//   reset deasserts, so an input already high at reset produces no rise flag.
//  edge_capture[i] next = detect[i] | (edge_capture[i] & ~clr[i]);
//   clr[i] = wr to addr 3 & (BIT_CLEARING ? writedata[i] : 1).
//   Simultaneous new edge and clear on same bit: set wins (flag stays 1).
//  irq = |(edge_capture & irq_mask), registered: asserts 1 cycle after the
//   capture/mask change that causes it; deasserts 1 cycle after the clearing write.
//  Reset values: readdata 0, irq 0, irq_mask 0, edge_capture 0, sync/prev 0.
//  Reset mid-operation: all state returns to reset values on that edge; any
//   in-flight edge is discarded; arming restarts.
//  Writes to addr 0/1 have no effect. Glitches shorter than 1 clk may be missed.
// TESTING
//  1 Reset with in_port=8'hFF held; release, wait 10 clk -> edge_capture=0, irq=0,
//    data read = 32'h000000FF.
//  2 in_port 0->8'h05 (EDGE_TYPE=0) -> edge_capture=8'h05 exactly SYNC_STAGES+1
//    clk later; readdata follows address with 1-clk latency.
//  3 irq_mask=8'h04, capture 8'h05 -> irq=1 one clk after capture; write addr3
//    = 32'h4 -> irq=0 next clk; edge_capture=8'h01.
//  4 Write addr3=32'h1 in same clk bit0 sees new rise -> edge_capture[0] stays 1.
//  5 BIT_CLEARING=0: write addr3=0 with edge_capture=8'h81 -> 0;
//    EDGE_TYPE=2: pulse bit7 1->0 -> edge_capture[7]=1 on both edges.
//  6 Assert reset 1 clk mid-activity (mask=8'hFF, capture=8'h3C) -> all regs 0,
//    irq=0 next clk; no capture during re-arm window.

Source files
------------

// File: rtl/freq_en_pio_edge.sv
// rtl/freq_en_pio_edge.sv - N-bit memory-mapped input PIO with synchroniser, edge capture and maskable irq
module freq_en_pio_edge #(
  parameter int WIDTH        = 8,  // input port width, 1..32
  parameter int SYNC_STAGES  = 2,  // synchroniser depth, 2..4
  parameter int EDGE_TYPE    = 0,  // 0 = rising, 1 = falling, 2 = any edge
  parameter int BIT_CLEARING = 1   // 1 = write-1-to-clear per bit, 0 = any write clears all
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  // Capture stays disabled until the synchroniser and prev flop hold real samples.
  localparam int ARM_CYCLES = SYNC_STAGES + 1;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // Synchroniser chain, index 0 is the flop nearest the pin.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_d;
  logic [WIDTH-1:0]                  prev_q;
  logic [WIDTH-1:0]                  prev_d;

  logic [2:0]        arm_cnt_q;
  logic [2:0]        arm_cnt_d;
  logic              armed;

  logic [WIDTH-1:0]  mask_q;
  logic [WIDTH-1:0]  mask_d;
  logic [WIDTH-1:0]  edge_q;
  logic [WIDTH-1:0]  edge_d;
  logic              irq_q;
  logic              irq_d;
  logic [31:0]       readdata_q;
  logic [31:0]       readdata_d;

  logic [WIDTH-1:0]  sync_s;
  logic [WIDTH-1:0]  detect;
  logic [WIDTH-1:0]  clr;
  logic              wr_en;

  // Bits of writedata above WIDTH are deliberately ignored.
  logic              unused_wdata;
  assign unused_wdata = ^writedata;

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign wr_en  = chipselect & ~write_n;
  assign armed  = (arm_cnt_q == 3'(ARM_CYCLES));

  // Shift the synchroniser and keep the previous synchronised sample for edge detection.
  always_comb begin
    sync_d = '0;
    if (SYNC_STAGES > 1) begin
      for (int i = SYNC_STAGES - 1; i > 0; i--) begin
        sync_d[i] = sync_q[i-1];
      end
    end
    sync_d[0] = in_port;
    prev_d    = sync_s;
  end

  // Arm counter saturates once the chain is fully populated after reset.
  always_comb begin
    arm_cnt_d = arm_cnt_q;
    if (!armed) begin
      arm_cnt_d = arm_cnt_q + 3'd1;
    end
  end

  // Edge detection on synchronised sample versus previous sample.
  always_comb begin
    detect = '0;
    if (EDGE_TYPE == 0) begin
      detect = sync_s & ~prev_q;
    end else if (EDGE_TYPE == 1) begin
      detect = ~sync_s & prev_q;
    end else begin
      detect = sync_s ^ prev_q;
    end
  end

  // Clear mask for edge_capture; a new edge on the same bit overrides the clear.
  always_comb begin
    clr = '0;
    if (wr_en && (address == ADDR_EDGE)) begin
      if (BIT_CLEARING != 0) begin
        clr = writedata[WIDTH-1:0];
      end else begin
        clr = '1;
      end
    end
  end

  // Register-file next state: mask, sticky edge flags, irq level.
  always_comb begin
    mask_d = mask_q;
    if (wr_en && (address == ADDR_MASK)) begin
      mask_d = writedata[WIDTH-1:0];
    end
    edge_d = (armed ? detect : '0) | (edge_q & ~clr);
    irq_d  = |(edge_q & mask_q);
  end

  // Read mux; readdata is registered every cycle from the current address.
  always_comb begin
    readdata_d = '0;
    unique case (address)
      ADDR_DATA: readdata_d[WIDTH-1:0] = sync_s;
      ADDR_MASK: readdata_d[WIDTH-1:0] = mask_q;
      ADDR_EDGE: readdata_d[WIDTH-1:0] = edge_q;
      default:   readdata_d = '0;
    endcase
  end

  // All state, cleared together on reset so arming restarts from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '0;
      prev_q     <= '0;
      arm_cnt_q  <= '0;
      mask_q     <= '0;
      edge_q     <= '0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      arm_cnt_q  <= arm_cnt_d;
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_freq_en_pio_edge.sv
// tb/tb_freq_en_pio_edge.sv - directed self-checking bench for freq_en_pio_edge
module tb_freq_en_pio_edge;

  logic        clk;
  logic        reset;

  logic [1:0]  address_a;
  logic        chipselect_a;
  logic        write_n_a;
  logic [31:0] writedata_a;
  logic [7:0]  in_port_a;
  logic [31:0] readdata_a;
  logic        irq_a;

  logic [1:0]  address_b;
  logic        chipselect_b;
  logic        write_n_b;
  logic [31:0] writedata_b;
  logic [7:0]  in_port_b;
  logic [31:0] readdata_b;
  logic        irq_b;

  int n_checks;
  int n_fail;
  logic [31:0] rd;

  freq_en_pio_edge #(
    .WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .BIT_CLEARING(1)
  ) dut_a (
    .clk(clk), .reset(reset), .address(address_a), .chipselect(chipselect_a),
    .write_n(write_n_a), .writedata(writedata_a), .in_port(in_port_a),
    .readdata(readdata_a), .irq(irq_a)
  );

  freq_en_pio_edge #(
    .WIDTH(8), .SYNC_STAGES(3), .EDGE_TYPE(2), .BIT_CLEARING(0)
  ) dut_b (
    .clk(clk), .reset(reset), .address(address_b), .chipselect(chipselect_b),
    .write_n(write_n_b), .writedata(writedata_b), .in_port(in_port_b),
    .readdata(readdata_b), .irq(irq_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input logic [1:0] a, input logic [31:0] d);
    address_a = a; writedata_a = d; chipselect_a = 1'b1; write_n_a = 1'b0;
    tick(1);
    chipselect_a = 1'b0; write_n_a = 1'b1;
  endtask

  task automatic wr_b(input logic [1:0] a, input logic [31:0] d);
    address_b = a; writedata_b = d; chipselect_b = 1'b1; write_n_b = 1'b0;
    tick(1);
    chipselect_b = 1'b0; write_n_b = 1'b1;
  endtask

  task automatic rd_a(input logic [1:0] a, output logic [31:0] d);
    address_a = a;
    tick(1);
    d = readdata_a;
  endtask

  task automatic rd_b(input logic [1:0] a, output logic [31:0] d);
    address_b = a;
    tick(1);
    d = readdata_b;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    address_a = 2'd0; chipselect_a = 1'b0; write_n_a = 1'b1; writedata_a = '0;
    address_b = 2'd0; chipselect_b = 1'b0; write_n_b = 1'b1; writedata_b = '0;
    in_port_a = 8'hFF;
    in_port_b = 8'h00;

    // 1: reset with inputs high, no spurious capture after release
    tick(3);
    check("reset_readdata", readdata_a, 32'h0);
    check("reset_irq", {31'b0, irq_a}, 32'h0);
    reset = 1'b0;
    tick(10);
    rd_a(2'd3, rd); check("t1_edge_capture", rd, 32'h0);
    check("t1_irq", {31'b0, irq_a}, 32'h0);
    rd_a(2'd0, rd); check("t1_data", rd, 32'h000000FF);
    rd_a(2'd1, rd); check("t1_reserved", rd, 32'h0);
    rd_a(2'd2, rd); check("t1_mask", rd, 32'h0);

    // 2: rising edges captured exactly SYNC_STAGES+1 clocks later
    in_port_a = 8'h00;
    tick(4);
    rd_a(2'd3, rd); check("t2_fall_ignored", rd, 32'h0);
    address_a = 2'd3;
    in_port_a = 8'h05;
    tick(3);
    check("t2_not_yet", readdata_a, 32'h0);
    tick(1);
    check("t2_capture", readdata_a, 32'h05);
    rd_a(2'd0, rd); check("t2_data", rd, 32'h05);
    rd_a(2'd1, rd); check("t2_reserved", rd, 32'h0);
    wr_a(2'd0, 32'hFFFF_FFFF);
    wr_a(2'd1, 32'hFFFF_FFFF);
    rd_a(2'd0, rd); check("t2_data_ro", rd, 32'h05);

    // 3: mask -> irq one clock later; clearing write drops irq one clock later
    wr_a(2'd2, 32'h04);
    check("t3_irq_lag", {31'b0, irq_a}, 32'h0);
    tick(1);
    check("t3_irq_set", {31'b0, irq_a}, 32'h1);
    wr_a(2'd3, 32'h04);
    check("t3_irq_hold", {31'b0, irq_a}, 32'h1);
    tick(1);
    check("t3_irq_clr", {31'b0, irq_a}, 32'h0);
    rd_a(2'd3, rd); check("t3_edge", rd, 32'h01);
    rd_a(2'd2, rd); check("t3_mask", rd, 32'h04);

    // 4: clear and new rise on the same bit in the same clock, set wins
    in_port_a = 8'h04;
    tick(4);
    rd_a(2'd3, rd); check("t4_sticky", rd, 32'h01);
    in_port_a = 8'h05;
    tick(2);
    wr_a(2'd3, 32'h01);
    rd_a(2'd3, rd); check("t4_set_wins", rd, 32'h01);
    wr_a(2'd3, 32'h01);
    rd_a(2'd3, rd); check("t4_cleared", rd, 32'h0);

    // 5: any-edge, clear-all instance (SYNC_STAGES=3)
    address_b = 2'd3;
    in_port_b = 8'h81;
    tick(4);
    check("t5_not_yet", readdata_b, 32'h0);
    tick(1);
    check("t5_capture", readdata_b, 32'h81);
    wr_b(2'd3, 32'h0);
    rd_b(2'd3, rd); check("t5_clear_all", rd, 32'h0);
    in_port_b = 8'h01;
    tick(4);
    check("t5_fall_not_yet", readdata_b, 32'h0);
    tick(1);
    check("t5_fall", readdata_b, 32'h80);
    wr_b(2'd3, 32'h0);
    rd_b(2'd3, rd); check("t5_clear2", rd, 32'h0);
    in_port_b = 8'h81;
    tick(5);
    rd_b(2'd3, rd); check("t5_rise", rd, 32'h80);
    wr_b(2'd2, 32'h80);
    check("t5_irq_lag", {31'b0, irq_b}, 32'h0);
    tick(1);
    check("t5_irq_set", {31'b0, irq_b}, 32'h1);
    wr_b(2'd3, 32'h0);
    tick(1);
    check("t5_irq_clr", {31'b0, irq_b}, 32'h0);

    // 6: reset mid-activity clears everything and re-arms
    in_port_a = 8'h00;
    tick(4);
    in_port_a = 8'h3C;
    tick(4);
    wr_a(2'd2, 32'hFF);
    tick(1);
    check("t6_irq_before", {31'b0, irq_a}, 32'h1);
    rd_a(2'd3, rd); check("t6_edge_before", rd, 32'h3C);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("t6_readdata", readdata_a, 32'h0);
    check("t6_irq", {31'b0, irq_a}, 32'h0);
    check("t6_irq_b", {31'b0, irq_b}, 32'h0);
    tick(10);
    check("t6_irq_later", {31'b0, irq_a}, 32'h0);
    rd_a(2'd3, rd); check("t6_edge_rearm", rd, 32'h0);
    rd_a(2'd2, rd); check("t6_mask", rd, 32'h0);
    rd_a(2'd0, rd); check("t6_data", rd, 32'h3C);
    rd_b(2'd3, rd); check("t6_edge_rearm_b", rd, 32'h0);
    rd_b(2'd2, rd); check("t6_mask_b", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
